uart_rx_gen: RTL and testbench
==============================

UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
- REQ-001 Parameter CLKS_PER_BIT, default 434: clock cycles per bit period; legal range 8..65535.
- REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
- REQ-003 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only under UART_RX_PARITY_EN.
- REQ-005 One clock; reset is synchronous and active-high.
- REQ-006 clk  input  1  system clock; all state updates on the rising edge.
- REQ-007 rst  input  1  synchronous, active-high reset.
- REQ-008 uart_rx  input  1  asynchronous serial line; idles high.
- REQ-009 rx_ack  input  1  consumer acknowledge of the held frame.
- REQ-010 rx_data  output  DATA_BITS  received word, LSB = first data bit on the line.
- REQ-011 rx_valid  output  1  rx_data and error flags are valid; held until acknowledged.
- REQ-012 frame_err  output  1  a stop bit of the held frame sampled low.
- REQ-013 parity_err  output  1  parity mismatch in the held frame; constant 0 when parity is disabled.
- REQ-014 overrun  output  1  sticky flag: a completed frame was dropped while rx_valid was high.
- REQ-015 busy  output  1  high in every state other than IDLE.

Function
- REQ-016 uart_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
- REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
- REQ-018 IDLE: rxs=0 -> START; the bit timer clears.
- REQ-019 START: at timer = CLKS_PER_BIT/2-1, rxs=1 -> IDLE (glitch rejected, no flags change); rxs=0 -> DATA with timer and bit index cleared.
- REQ-020 DATA: sample rxs at timer = CLKS_PER_BIT-1 into shift position bit_index, LSB first.
- REQ-021 DATA: after bit DATA_BITS-1 -> PARITY if parity is enabled, else STOP.
- REQ-022 PARITY: sample one bit at timer = CLKS_PER_BIT-1, then -> STOP.
- REQ-023 STOP: sample STOP_BITS bits at timer = CLKS_PER_BIT-1; any low sample sets the frame's frame error.
- REQ-024 STOP: after the last stop sample -> IDLE in the same cycle, so the receiver rearms at mid-stop-bit.
- REQ-025 Completion: the cycle after the last stop sample, rx_data, frame_err and parity_err load and rx_valid=1.
- REQ-026 rx_ack=1 while rx_valid=1 clears rx_valid and overrun on the next cycle; rx_ack while rx_valid=0 is ignored.
- REQ-027 Completion with rx_valid=1 and no rx_ack that cycle: the new frame is discarded, held data is unchanged, overrun=1.
- REQ-028 Completion in the same cycle as rx_ack: the new frame loads, rx_valid stays 1, overrun=0.
- REQ-029 Frames with frame_err or parity_err are still delivered with the flag set.
- REQ-030 The bit timer is ceil(log2(CLKS_PER_BIT)) bits wide and never wraps past CLKS_PER_BIT-1.

Reset
- REQ-031 rst SHALL force IDLE, clear timer and bit index, preset synchronizer flops to 1, and drive rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0 on the next edge.
- REQ-032 rst mid-frame abandons the frame; no partial data is delivered.

Configuration
- REQ-033 Macro UART_RX_PARITY_EN defined: the PARITY state exists; parity_err = (XOR of data bits ^ parity bit) != PARITY_ODD.
- REQ-034 Macro UART_RX_PARITY_EN undefined: no PARITY state and no parity logic; parity_err is tied 0.

Structure
- REQ-035 Package uart_pkg SHALL hold the state enum type rx_state_t and the legal-range constants for DATA_BITS and STOP_BITS.
- REQ-036 Sub-module uart_bit_timer SHALL hold the counter, with inputs clr/en and outputs at_half/at_full.

Verification (bench CLKS_PER_BIT=16, 8N1 unless stated)
- REQ-037 Frame 0xA5 -> rx_data=0xA5, rx_valid=1, frame_err=0, 2+8+9*16+1 cycles after the falling start edge.
- REQ-038 Line low for 4 cycles then high -> busy returns to 0, no rx_valid.
- REQ-039 Frame 0x3C with stop bit low -> rx_valid=1, rx_data=0x3C, frame_err=1.
- REQ-040 Frames 0x11 then 0x22, no ack -> rx_data=0x11, overrun=1; rx_ack -> rx_valid=0, overrun=0.
- REQ-041 UART_RX_PARITY_EN, even parity: 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
- REQ-042 rst at data bit 3 -> all outputs 0 next cycle; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and range constants for the UART receiver
//
// Holds the receiver state enum (rx_state_t) and the legal ranges of the
// DATA_BITS and STOP_BITS parameters. The PARITY state exists only when the
// UART_RX_PARITY_EN macro is defined.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Wide enough to count DATA_BITS_MAX data bits or STOP_BITS_MAX stop bits.
    localparam int IDX_W = 4;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter for the UART receiver
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clr      in   force the count to zero (wins over en)
//   en       in   advance the count; wraps to zero after CLKS_PER_BIT-1
//   at_half  out  count equals CLKS_PER_BIT/2-1
//   at_full  out  count equals CLKS_PER_BIT-1
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_half,
    output logic at_full
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign at_half = (cnt_q == HALF_M1);
    assign at_full = (cnt_q == FULL_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Wrap explicitly so the count never passes CLKS_PER_BIT-1,
            // even when CLKS_PER_BIT is not a power of two.
            cnt_d = at_full ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// rtl/uart_rx_gen.sv - parameterised UART receiver with held-frame handshake
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   uart_rx     in   asynchronous serial line, idles high
//   rx_ack      in   consumer acknowledge of the held frame
//   rx_data     out  received word, LSB = first data bit on the line
//   rx_valid    out  rx_data and error flags valid, held until acknowledged
//   frame_err   out  a stop bit of the held frame sampled low
//   parity_err  out  parity mismatch in the held frame (0 without parity)
//   overrun     out  sticky: a completed frame was dropped while rx_valid=1
//   busy        out  receiver is not idle
//
// Optional feature: define UART_RX_PARITY_EN to receive a parity bit after
// the data bits (PARITY_ODD selects odd parity).
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_rx_gen: parameter out of range");
    end

    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic                 sync1_q;
    logic                 rxs_q;
    rx_state_t            state_q,  state_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic                 ferr_q,   ferr_d;
    logic                 done_q,   done_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 fe_q,     fe_d;
    logic                 ovr_q,    ovr_d;
    logic                 tmr_clr;
    logic                 tmr_en;
    logic                 at_half;
    logic                 at_full;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                 par_q,    par_d;
    logic                 pe_q,     pe_d;
    logic                 frame_perr;

    assign frame_perr = ((^shift_q) ^ par_q) != PAR_ODD;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .at_half (at_half),
        .at_full (at_full)
    );

    // Receive FSM: bit timing, shifting and per-frame error accumulation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                tmr_en  = 1'b0;
                if (!rxs_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit; a high line means the
                // falling edge was a glitch.
                if (at_half) begin
                    tmr_clr = 1'b1;
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (at_full) begin
                    // Shift in from the top: after DATA_BITS samples the
                    // first bit received sits at bit 0.
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_full) begin
                    par_d   = rxs_q;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (at_full) begin
                    ferr_d = ferr_q | ~rxs_q;
                    if (idx_q == STOP_LAST) begin
                        // Rearm at mid stop bit so back-to-back frames are
                        // not missed.
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Held-frame handshake: a completion loads unless a frame is already
    // held and not being acknowledged in the same cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        pe_d    = pe_q;
`endif
        if (done_q) begin
            if (valid_q && !rx_ack) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                fe_d    = ferr_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
                pe_d    = frame_perr;
`endif
            end
        end else if (valid_q && rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            sync1_q <= uart_rx;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb/tb_uart_rx_gen.sv - self-checking bench for uart_rx_gen
module tb_uart_rx_gen;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Edges from the first start-bit edge to the edge that raises rx_valid.
    localparam int LAT = 2 + CPB / 2 + (DB + PB + SB) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          rx_ack;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_rx_gen #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        logic          par;
        logic [DB-1:0] exp_data;
        logic          exp_ferr;
        logic          exp_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Parity bit that makes the frame correct under the configured parity.
    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    // Reference rule for the parity flag of a received frame.
    function automatic logic model_perr(input logic [DB-1:0] d, input logic par);
`ifdef UART_RX_PARITY_EN
        return ((^d) ^ par) != (PODD != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            uart_rx = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par;
        tick(CPB);
`endif
        for (int s = 0; s < SB; s++) begin
            uart_rx = stop;
            tick(CPB);
        end
        uart_rx = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [DB-1:0] d,
                               input logic fe, input logic pe);
        @(negedge clk);
        chk({tag, ".valid"}, rx_valid, 1);
        chk({tag, ".data"}, rx_data, d);
        chk({tag, ".ferr"}, frame_err, fe);
        chk({tag, ".perr"}, parity_err, pe);
    endtask

    task automatic do_ack(input string tag);
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        @(negedge clk);
        chk({tag, ".ack_valid"}, rx_valid, 0);
        chk({tag, ".ack_ovr"}, overrun, 0);
    endtask

    initial begin
        logic [DB-1:0] rd;
        logic          rstop;
        logic          rpar;

        rst     = 1'b1;
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst.data", rx_data, 0);
        chk("rst.valid", rx_valid, 0);
        chk("rst.ferr", frame_err, 0);
        chk("rst.perr", parity_err, 0);
        chk("rst.ovr", overrun, 0);
        chk("rst.busy", busy, 0);
        rst = 1'b0;
        tick(5);

        // Completion latency, counted from the first start-bit edge.
        fork
            send_frame(8'hA5, 1'b1, good_par(8'hA5));
            begin
                @(posedge clk);
                repeat (LAT) @(posedge clk);
                @(negedge clk);
                chk("lat.before", rx_valid, 0);
                @(posedge clk);
                @(negedge clk);
                chk("lat.at", rx_valid, 1);
            end
        join
        check_frame("a5", 8'hA5, 1'b0, 1'b0);
        do_ack("a5");
        tick(20);

        // Short low pulse on the line is rejected at mid start bit.
        @(posedge clk);
        #1 uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        @(negedge clk);
        chk("glitch.busy_hi", busy, 1);
        tick(20);
        @(negedge clk);
        chk("glitch.busy_lo", busy, 0);
        chk("glitch.valid", rx_valid, 0);

        vecs.push_back('{8'hA5, 1'b1, good_par(8'hA5), 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, good_par(8'h3C), 8'h3C, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, good_par(8'h00), 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, good_par(8'hFF), 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 1'b1, good_par(8'h80), 8'h80, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b0, good_par(8'h01), 8'h01, 1'b1, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_data,
                        vecs[i].exp_ferr, vecs[i].exp_perr);
            do_ack($sformatf("vec%0d", i));
            tick(20);
        end

        // Second frame dropped while the first is held.
        send_frame(8'h11, 1'b1, good_par(8'h11));
        tick(20);
        send_frame(8'h22, 1'b1, good_par(8'h22));
        @(negedge clk);
        chk("ovr.valid", rx_valid, 1);
        chk("ovr.data", rx_data, 8'h11);
        chk("ovr.flag", overrun, 1);
        do_ack("ovr");
        tick(20);

        // Acknowledge in the completion cycle: new frame loads, overrun clears.
        send_frame(8'h33, 1'b1, good_par(8'h33));
        tick(20);
        send_frame(8'h55, 1'b1, good_par(8'h55));
        @(negedge clk);
        chk("same.pre_ovr", overrun, 1);
        tick(20);
        fork
            send_frame(8'h44, 1'b1, good_par(8'h44));
            begin
                @(posedge clk);
                repeat (LAT) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
                @(negedge clk);
                chk("same.valid", rx_valid, 1);
                chk("same.data", rx_data, 8'h44);
                chk("same.ovr", overrun, 0);
            end
        join
        do_ack("same");
        tick(20);

        // Reset in the middle of data bit 3 while a frame is held.
        send_frame(8'hC3, 1'b1, good_par(8'hC3));
        tick(20);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        tick(CPB);
        rd = 8'h96;
        for (int i = 0; i < 3; i++) begin
            uart_rx = rd[i];
            tick(CPB);
        end
        uart_rx = rd[3];
        tick(CPB / 2);
        @(negedge clk);
        chk("mid.busy", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        uart_rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid.data", rx_data, 0);
        chk("mid.valid", rx_valid, 0);
        chk("mid.ferr", frame_err, 0);
        chk("mid.perr", parity_err, 0);
        chk("mid.ovr", overrun, 0);
        chk("mid.busy_lo", busy, 0);
        rst = 1'b0;
        tick(CPB * 12);
        @(negedge clk);
        chk("mid.no_partial", rx_valid, 0);
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        check_frame("after_rst", 8'h5A, 1'b0, 1'b0);
        do_ack("after_rst");
        tick(20);

        // Randomised frames against the reference rules.
        for (int i = 0; i < 24; i++) begin
            rd    = DB'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = 1'($urandom_range(0, 1));
            send_frame(rd, rstop, rpar);
            check_frame($sformatf("rnd%0d", i), rd, ~rstop, model_perr(rd, rpar));
            do_ack($sformatf("rnd%0d", i));
            tick(int'($urandom_range(12, 30)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
